mem_stage_lsu: RTL and testbench

- Parametrised successor to the single-cycle MEM pipeline stage.
- Resolves conditional and unconditional branches, including CBZ and CBNZ.
- Performs sized, sign-aware loads and stores against an internal data memory with configurable access latency, stalling upstream while busy.
- Registers results into the MEM/WB pipeline register with a valid bit and a misalignment flag.

---
 rtl/mem_stage_lsu.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM pipeline stage: resolves branches, performs sized, sign-aware loads
//   and stores against an internal data memory with configurable access
//   latency, and registers results into the MEM/WB pipeline register.
//
// Parameters
//   WORD        datapath width (32 or 64)
//   DM_DEPTH    number of WORD-wide memory entries (power of two)
//   MEM_LATENCY cycles per memory access (>= 1, 1 = no stall)
//
// Ports
//   im_clk, im_reset                 clock, synchronous active-high reset
//   valid_in                         instruction present
//   uncondbranch, branch,
//   branch_on_nz, zero               branch controls -> pc_src (comb)
//   mem_read, mem_write, mem_size,
//   mem_signed                       memory access controls
//   pc_in, mem_to_reg_in,
//   alu_result, read_data2           datapath inputs (address / store data)
//   pc_src, stall                    combinational outputs
//   pc_out, mem_to_reg_out,
//   alu_result_out, read_data,
//   valid_out, misaligned_out        MEM/WB pipeline register
module mem_stage_lsu #(
  parameter int WORD        = 64,
  parameter int DM_DEPTH    = 128,
  parameter int MEM_LATENCY = 1
) (
  input  logic            im_clk,
  input  logic            im_reset,
  input  logic            valid_in,
  input  logic            uncondbranch,
  input  logic            branch,
  input  logic            branch_on_nz,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_signed,
  input  logic            zero,
  input  logic [WORD-1:0] pc_in,
  input  logic            mem_to_reg_in,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] read_data2,
  output logic            pc_src,
  output logic            stall,
  output logic [WORD-1:0] pc_out,
  output logic            mem_to_reg_out,
  output logic [WORD-1:0] alu_result_out,
  output logic [WORD-1:0] read_data,
  output logic            valid_out,
  output logic            misaligned_out
);

  localparam int  BYTES = WORD / 8;
  localparam int  OFF_W = $clog2(BYTES);
  localparam int  IDX_W = $clog2(DM_DEPTH);
  localparam int  CNT_W = $clog2(MEM_LATENCY + 1);
  localparam bit  MULTI = (MEM_LATENCY > 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  logic [WORD-1:0]  r_mem [DM_DEPTH];

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_complete;

  logic [WORD-1:0]  r_pc_out;
  logic             r_mem_to_reg_out;
  logic [WORD-1:0]  r_alu_result_out;
  logic [WORD-1:0]  r_read_data;
  logic             r_valid_out;
  logic             r_misaligned_out;

  // ---------------------------------------------------------------- decode
  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_align_mask;
  logic [BYTES-1:0] w_size_mask;
  logic [WORD-1:0]  w_low_mask;
  logic             w_size_ok;
  logic             w_fault;
  logic             w_acc;
  logic             w_is_load;

  assign w_off = alu_result[OFF_W-1:0];
  assign w_idx = alu_result[OFF_W +: IDX_W];

  assign pc_src = valid_in & (uncondbranch | (branch & (zero ^ branch_on_nz)));

  always_comb begin
    w_align_mask = '0;
    w_size_mask  = '0;
    w_low_mask   = '0;
    case (mem_size)
      2'b00: begin
        w_align_mask = '0;
        w_size_mask  = BYTES'(1);
        w_low_mask   = WORD'(8'hFF);
      end
      2'b01: begin
        w_align_mask = OFF_W'(1);
        w_size_mask  = BYTES'(3);
        w_low_mask   = WORD'(16'hFFFF);
      end
      2'b10: begin
        w_align_mask = OFF_W'(3);
        w_size_mask  = BYTES'(15);
        w_low_mask   = WORD'(32'hFFFF_FFFF);
      end
      default: begin
        w_align_mask = OFF_W'(7);
        w_size_mask  = '1;
        w_low_mask   = '1;
      end
    endcase
  end

  // A dword access on a 32-bit datapath cannot be honoured; it faults.
  assign w_size_ok = !((WORD == 32) && (mem_size == 2'b11));
  assign w_fault   = (mem_read | mem_write) & ((|(w_off & w_align_mask)) | ~w_size_ok);
  assign w_acc     = valid_in & (mem_read | mem_write) & ~w_fault;
  // A simultaneous read and write behaves as a store.
  assign w_is_load = mem_read & ~mem_write;

  // ------------------------------------------------------ load extraction
  logic [WORD-1:0] w_rword;
  logic [WORD-1:0] w_rshift;
  logic            w_sign;
  logic [WORD-1:0] w_load_val;

  assign w_rword  = r_mem[w_idx];
  assign w_rshift = w_rword >> {w_off, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    case (mem_size)
      2'b00:   w_sign = w_rshift[7];
      2'b01:   w_sign = w_rshift[15];
      2'b10:   w_sign = w_rshift[31];
      default: w_sign = w_rshift[WORD-1];
    endcase
  end

  assign w_load_val = (w_rshift & w_low_mask) | ((mem_signed & w_sign) ? ~w_low_mask : '0);

  // --------------------------------------------------------- store merge
  // Read-modify-write: unselected lanes keep the current entry contents.
  logic [BYTES-1:0] w_be;
  logic [WORD-1:0]  w_wdata;
  logic [WORD-1:0]  w_merged;

  assign w_be    = w_size_mask << w_off;
  assign w_wdata = read_data2 << {w_off, 3'b000};

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_be[gi] ? w_wdata[8*gi +: 8] : w_rword[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge im_clk) begin
    if (!im_reset && w_complete && mem_write) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge im_clk) begin
    if (im_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc && MULTI) begin
          w_state_next = S_BUSY;
          w_cnt_next   = CNT_W'(MEM_LATENCY - 1);
        end
      end
      default: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  // The access completes on the last of its MEM_LATENCY edges, which is
  // the first edge at which stall is low.
  always_comb begin
    stall      = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          stall      = MULTI;
          w_complete = !MULTI;
        end
      end
      default: begin
        if (r_cnt > CNT_W'(1)) begin
          stall = 1'b1;
        end else begin
          w_complete = w_acc;
        end
      end
    endcase
  end

  // ----------------------------------------------------- MEM/WB register
  always_ff @(posedge im_clk) begin
    if (im_reset) begin
      r_pc_out         <= '0;
      r_mem_to_reg_out <= 1'b0;
      r_alu_result_out <= '0;
      r_read_data      <= '0;
      r_valid_out      <= 1'b0;
      r_misaligned_out <= 1'b0;
    end else if (stall) begin
      r_valid_out <= 1'b0;
    end else begin
      r_pc_out         <= pc_in;
      r_mem_to_reg_out <= mem_to_reg_in;
      r_alu_result_out <= alu_result;
      r_read_data      <= (w_acc && w_is_load) ? w_load_val : '0;
      r_valid_out      <= valid_in;
      r_misaligned_out <= valid_in & w_fault;
    end
  end

  assign pc_out         = r_pc_out;
  assign mem_to_reg_out = r_mem_to_reg_out;
  assign alu_result_out = r_alu_result_out;
  assign read_data      = r_read_data;
  assign valid_out      = r_valid_out;
  assign misaligned_out = r_misaligned_out;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: two instances (latency 1 and latency 3),
// directed steps followed by random transactions checked against a
// byte-addressed reference memory.
module tb_mem_stage_lsu;

  localparam int MEMB = 128 * 8;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst  [2];
  logic        t_v    [2];
  logic        t_ub   [2];
  logic        t_br   [2];
  logic        t_bnz  [2];
  logic        t_rd   [2];
  logic        t_wr   [2];
  logic [1:0]  t_sz   [2];
  logic        t_sg   [2];
  logic        t_z    [2];
  logic [63:0] t_pc   [2];
  logic        t_m2r  [2];
  logic [63:0] t_alu  [2];
  logic [63:0] t_wd   [2];
  logic        o_src  [2];
  logic        o_stl  [2];
  logic [63:0] o_pc   [2];
  logic        o_m2r  [2];
  logic [63:0] o_alu  [2];
  logic [63:0] o_rd   [2];
  logic        o_v    [2];
  logic        o_mis  [2];

  mem_stage_lsu #(.WORD(64), .DM_DEPTH(128), .MEM_LATENCY(1)) dut_l1 (
    .im_clk(clk), .im_reset(t_rst[0]), .valid_in(t_v[0]), .uncondbranch(t_ub[0]),
    .branch(t_br[0]), .branch_on_nz(t_bnz[0]), .mem_read(t_rd[0]), .mem_write(t_wr[0]),
    .mem_size(t_sz[0]), .mem_signed(t_sg[0]), .zero(t_z[0]), .pc_in(t_pc[0]),
    .mem_to_reg_in(t_m2r[0]), .alu_result(t_alu[0]), .read_data2(t_wd[0]),
    .pc_src(o_src[0]), .stall(o_stl[0]), .pc_out(o_pc[0]), .mem_to_reg_out(o_m2r[0]),
    .alu_result_out(o_alu[0]), .read_data(o_rd[0]), .valid_out(o_v[0]),
    .misaligned_out(o_mis[0])
  );

  mem_stage_lsu #(.WORD(64), .DM_DEPTH(128), .MEM_LATENCY(3)) dut_l3 (
    .im_clk(clk), .im_reset(t_rst[1]), .valid_in(t_v[1]), .uncondbranch(t_ub[1]),
    .branch(t_br[1]), .branch_on_nz(t_bnz[1]), .mem_read(t_rd[1]), .mem_write(t_wr[1]),
    .mem_size(t_sz[1]), .mem_signed(t_sg[1]), .zero(t_z[1]), .pc_in(t_pc[1]),
    .mem_to_reg_in(t_m2r[1]), .alu_result(t_alu[1]), .read_data2(t_wd[1]),
    .pc_src(o_src[1]), .stall(o_stl[1]), .pc_out(o_pc[1]), .mem_to_reg_out(o_m2r[1]),
    .alu_result_out(o_alu[1]), .read_data(o_rd[1]), .valid_out(o_v[1]),
    .misaligned_out(o_mis[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: one byte array per instance, byte address mod size.
  logic [7:0] mdl [2][MEMB];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] mdl_load(input int d, input int a, input int sb, input bit sg);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < sb; i++) r[8*i +: 8] = mdl[d][(a + i) % MEMB];
    if (sg && sb < 8 && r[8*sb-1]) r = r | ~((64'd1 << (8*sb)) - 64'd1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    t_v[d] = 0; t_ub[d] = 0; t_br[d] = 0; t_bnz[d] = 0; t_rd[d] = 0; t_wr[d] = 0;
    t_sz[d] = 0; t_sg[d] = 0; t_z[d] = 0; t_pc[d] = 0; t_m2r[d] = 0; t_alu[d] = 0;
    t_wd[d] = 0;
  endtask

  // Drive one instruction, hold it for the whole expected occupancy, check
  // pc_src/stall every cycle, bubbles while stalled, and the MEM/WB entry.
  task automatic txn(input int d, input bit v, input bit ub, input bit br, input bit bnz,
                     input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                     input bit z, input bit m2r, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] pc);
    int a, sb, lat;
    bit flt, acc, take;
    logic [63:0] exp_rd;
    @(negedge clk);
    t_v[d] = v; t_ub[d] = ub; t_br[d] = br; t_bnz[d] = bnz; t_rd[d] = rd; t_wr[d] = wr;
    t_sz[d] = sz; t_sg[d] = sg; t_z[d] = z; t_m2r[d] = m2r; t_alu[d] = addr;
    t_wd[d] = wdata; t_pc[d] = pc;
    sb   = 1 << sz;
    a    = int'(addr % 64'(MEMB));
    flt  = (rd || wr) && (a % sb != 0);
    acc  = v && (rd || wr) && !flt;
    lat  = acc ? lat_of(d) : 1;
    take = v && (ub || (br && (z != bnz)));
    exp_rd = (acc && rd && !wr) ? mdl_load(d, a, sb, sg) : 64'd0;
    for (int k = 1; k <= lat; k++) begin
      #1;
      chk("pc_src", o_src[d], take);
      chk("stall", o_stl[d], k < lat);
      @(posedge clk);
      #1;
      if (k < lat) begin
        chk("bubble_valid", o_v[d], 0);
        @(negedge clk);
      end else begin
        chk("valid_out", o_v[d], v);
        chk("misaligned", o_mis[d], v && flt);
        chk("read_data", o_rd[d], exp_rd);
        chk("pc_out", o_pc[d], pc);
        chk("alu_out", o_alu[d], addr);
        chk("m2r_out", o_m2r[d], m2r);
      end
    end
    if (acc && wr) begin
      for (int i = 0; i < sb; i++) mdl[d][(a + i) % MEMB] = wdata[8*i +: 8];
    end
    $display("txn dut=%0d v=%0d rd=%0d wr=%0d sz=%0d sg=%0d addr=%h wd=%h -> rd_out=%h mis=%0d",
             d, v, rd, wr, sz, sg, addr, wdata, o_rd[d], o_mis[d]);
  endtask

  task automatic load(input int d, input logic [1:0] sz, input bit sg, input logic [63:0] addr);
    txn(d, 1, 0, 0, 0, 1, 0, sz, sg, 0, 1, addr, 64'd0, 64'h100);
  endtask

  task automatic store(input int d, input logic [1:0] sz, input logic [63:0] addr,
                       input logic [63:0] data);
    txn(d, 1, 0, 0, 0, 0, 1, sz, 0, 0, 0, addr, data, 64'h200);
  endtask

  task automatic rand_txn(input int d);
    int op, base, sb;
    logic [1:0] sz;
    logic [63:0] addr;
    bit v, rd, wr, br, ub;
    op   = $urandom_range(0, 5);
    sz   = 2'($urandom_range(0, 3));
    sb   = 1 << sz;
    base = $urandom_range(0, MEMB - 1);
    if ($urandom_range(0, 3) != 0) base = base - (base % sb);
    addr = {$urandom, $urandom};
    addr[9:0] = 10'(base);
    v  = ($urandom_range(0, 9) != 0);
    br = (op == 1);
    ub = (op == 2);
    rd = (op == 3) || (op == 5);
    wr = (op == 4) || (op == 5);
    txn(d, v, ub, br, 1'($urandom), rd, wr, sz, 1'($urandom), 1'($urandom), 1'($urandom),
        addr, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      t_rst[d] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", o_v[d], 0);
      chk("reset_rd", o_rd[d], 0);
      chk("reset_pc", o_pc[d], 0);
      chk("reset_mis", o_mis[d], 0);
      chk("reset_stall", o_stl[d], 0);
    end
    @(negedge clk);
    t_rst[0] = 0;
    t_rst[1] = 0;

    // Fill both memories so every later load has a defined value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 128; i++) store(d, 2'b11, 64'(i * 8), {$urandom, $urandom});

    // Latency 1: dword store/load, sub-word store and signed/unsigned loads.
    store(0, 2'b11, 64'h10, 64'h1122334455667788);
    load(0, 2'b11, 0, 64'h10);
    chk("dword_load", o_rd[0], 64'h1122334455667788);
    store(0, 2'b00, 64'h13, 64'hF0);
    load(0, 2'b00, 1, 64'h13);
    chk("byte_signed", o_rd[0], 64'hFFFFFFFFFFFFFFF0);
    load(0, 2'b00, 0, 64'h13);
    chk("byte_unsigned", o_rd[0], 64'h00000000000000F0);
    load(0, 2'b11, 0, 64'h10);
    chk("dword_after_byte", o_rd[0], 64'h11223344F0667788);

    // Misaligned half load faults without touching memory.
    load(0, 2'b01, 1, 64'h11);
    chk("half_mis_flag", o_mis[0], 1);
    chk("half_mis_data", o_rd[0], 0);
    txn(0, 1, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 64'h12, 64'hDEADBEEF, 64'h0);
    chk("store_mis_flag", o_mis[0], 1);
    load(0, 2'b11, 0, 64'h10 + 64'(MEMB));
    chk("alias_load", o_rd[0], 64'h11223344F0667788);

    // Branch resolution.
    @(negedge clk);
    idle_inputs(0);
    t_v[0] = 1; t_br[0] = 1; t_z[0] = 1; t_bnz[0] = 0;
    #1 chk("cbz_taken", o_src[0], 1);
    t_bnz[0] = 1;
    #1 chk("cbnz_not_taken", o_src[0], 0);
    t_br[0] = 0; t_ub[0] = 1; t_v[0] = 0;
    #1 chk("b_invalid", o_src[0], 0);
    txn(0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 64'h5, 64'h0, 64'h4000);
    txn(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0, 64'h8, 64'h0, 64'h8000);

    // Latency 3: stalled loads, back to back.
    store(1, 2'b11, 64'h10, 64'hCAFEF00D12345678);
    load(1, 2'b11, 0, 64'h10);
    chk("lat3_load", o_rd[1], 64'hCAFEF00D12345678);
    load(1, 2'b10, 1, 64'h14);
    chk("lat3_word_signed", o_rd[1], 64'hFFFFFFFFCAFEF00D);
    load(1, 2'b01, 1, 64'h11);
    chk("lat3_mis_no_stall", o_mis[1], 1);

    // Reset in the second cycle of a latency-3 store aborts it.
    @(negedge clk);
    t_v[1] = 1; t_rd[1] = 0; t_wr[1] = 1; t_sz[1] = 2'b11; t_alu[1] = 64'h10;
    t_wd[1] = 64'h0BADC0DE0BADC0DE;
    #1 chk("abort_stall_c1", o_stl[1], 1);
    @(negedge clk);
    t_rst[1] = 1;
    idle_inputs(1);
    @(posedge clk);
    #1;
    chk("abort_valid", o_v[1], 0);
    chk("abort_rd", o_rd[1], 0);
    chk("abort_alu", o_alu[1], 0);
    chk("abort_pc", o_pc[1], 0);
    @(negedge clk);
    t_rst[1] = 0;
    #1 chk("abort_stall_after", o_stl[1], 0);
    load(1, 2'b11, 0, 64'h10);
    chk("abort_old_value", o_rd[1], 64'hCAFEF00D12345678);

    // Random traffic on both instances.
    for (int n = 0; n < 300; n++) rand_txn(0);
    for (int n = 0; n < 150; n++) rand_txn(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
